// File: rtl/ldpc_encoder_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_encoder_pkg
// Shared definitions for the LDPC encoder back end: the default frame
// geometry used by the delay FIFO, the parity calculator and the codeword
// assembler, the assembler state encoding, and a small elaboration helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ldpc_encoder_pkg;

  // Default frame geometry shared by the encoder stages.
  localparam int LDPC_WIDTH      = 8;
  localparam int LDPC_SYS_WORDS  = 64;
  localparam int LDPC_PAR_WORDS  = 32;
  localparam int LDPC_PUNC_WORDS = 2;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SYS  = 2'd1,
    ST_PAR  = 2'd2
  } ldpc_asm_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ldpc_out_slice.sv
// ---------------------------------------------------------------------------
// ldpc_out_slice
// One-entry registered valid/ready output stage. Holds the codeword word,
// its valid and its last flag, and tells the producer whether a new word
// can be loaded this cycle.
//
// Ports:
//   i_clock      rising-edge clock
//   i_reset      synchronous active-high reset (clears valid, data, last)
//   i_load       load i_load_data / i_load_last into the register this cycle
//   i_load_data  word to load
//   i_load_last  last-word flag to load
//   i_out_ready  downstream accept
//   o_slot_free  register empty or being drained this cycle
//   o_out_data   registered codeword word
//   o_out_valid  registered valid
//   o_out_last   registered last-word flag
// ---------------------------------------------------------------------------
module ldpc_out_slice
  import ldpc_encoder_pkg::*;
#(
  parameter int WIDTH = LDPC_WIDTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_load_last,
  input  logic             i_out_ready,
  output logic             o_slot_free,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (i_load) begin
      data_d  = i_load_data;
      valid_d = 1'b1;
      last_d  = i_load_last;
    end else if (valid_q && i_out_ready) begin
      // Drained with no replacement: drop valid and do not leave a stale
      // last flag behind on the idle register.
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_slot_free = !valid_q || i_out_ready;
  assign o_out_data  = data_q;
  assign o_out_valid = valid_q;
  assign o_out_last  = last_q;

endmodule

// File: rtl/ldpc_codeword_assembler.sv
// ---------------------------------------------------------------------------
// ldpc_codeword_assembler
// Final LDPC encoder stage. For every frame it takes SYS_WORDS systematic
// words from the delay FIFO, then PAR_WORDS parity words from the parity
// path, and forwards them as one contiguous codeword stream with a
// last-word flag through a single registered valid/ready output.
//
// Optional build macro: LDPC_ASM_PUNCTURE_EN
//   When defined, the first PUNC_WORDS systematic words of each frame are
//   consumed from the FIFO but never emitted.
//
// Ports:
//   i_clock      rising-edge clock
//   i_reset      synchronous active-high reset
//   i_sys_data   systematic word       i_sys_valid / o_sys_ready handshake
//   i_par_data   parity word           i_par_valid / o_par_ready handshake
//   o_out_data   codeword word         o_out_valid / i_out_ready handshake
//   o_out_last   high with the final parity word of each frame
// ---------------------------------------------------------------------------
module ldpc_codeword_assembler
  import ldpc_encoder_pkg::*;
#(
  parameter int WIDTH      = LDPC_WIDTH,
  parameter int SYS_WORDS  = LDPC_SYS_WORDS,
  parameter int PAR_WORDS  = LDPC_PAR_WORDS,
  parameter int PUNC_WORDS = LDPC_PUNC_WORDS
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sys_data,
  input  logic             i_sys_valid,
  output logic             o_sys_ready,
  input  logic [WIDTH-1:0] i_par_data,
  input  logic             i_par_valid,
  output logic             o_par_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last,
  input  logic             i_out_ready
);

  localparam int CNT_W = $clog2(max_int(SYS_WORDS, PAR_WORDS));
  localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_WORDS - 1);
  localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(PAR_WORDS - 1);

  if (SYS_WORDS < 2) begin : g_chk_sys
    $error("ldpc_codeword_assembler: SYS_WORDS must be >= 2");
  end
  if (PAR_WORDS < 1) begin : g_chk_par
    $error("ldpc_codeword_assembler: PAR_WORDS must be >= 1");
  end

`ifdef LDPC_ASM_PUNCTURE_EN
  if (SYS_WORDS <= PUNC_WORDS) begin : g_chk_punc
    $error("ldpc_codeword_assembler: SYS_WORDS must exceed PUNC_WORDS");
  end
  if (PUNC_WORDS < 0) begin : g_chk_punc_neg
    $error("ldpc_codeword_assembler: PUNC_WORDS must be >= 0");
  end
  localparam int DROP_WORDS = PUNC_WORDS;
`else
  // Puncturing compiled out: PUNC_WORDS has no effect on this build.
  localparam int DROP_WORDS = 0 * PUNC_WORDS;
`endif

  ldpc_asm_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             slot_free;
  logic             punc_phase;
  logic             sys_ready, par_ready;
  logic             sys_acc, par_acc;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             load_last;

  // Dropped words need no output slot, so they are taken even while the
  // output register is stalled.
  assign punc_phase = (state_q == ST_SYS) && (int'(cnt_q) < DROP_WORDS);

  // State and word-counter registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_SYS;
        cnt_d   = '0;
      end
      ST_SYS: begin
        if (sys_acc) begin
          if (cnt_q == SYS_LAST) begin
            cnt_d   = '0;
            state_d = ST_PAR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (par_acc) begin
          if (cnt_q == PAR_LAST) begin
            cnt_d   = '0;
            state_d = ST_SYS;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Readies, accepts and output-register load.
  always_comb begin
    sys_ready = 1'b0;
    par_ready = 1'b0;
    case (state_q)
      ST_SYS:  sys_ready = slot_free || punc_phase;
      ST_PAR:  par_ready = slot_free;
      default: ;
    endcase

    sys_acc = sys_ready && i_sys_valid;
    par_acc = par_ready && i_par_valid;

    load      = 1'b0;
    load_data = i_sys_data;
    load_last = 1'b0;
    if (par_acc) begin
      load      = 1'b1;
      load_data = i_par_data;
      load_last = (cnt_q == PAR_LAST);
    end else if (sys_acc && !punc_phase) begin
      load = 1'b1;
    end
  end

  assign o_sys_ready = sys_ready;
  assign o_par_ready = par_ready;

  // Output register stage.
  ldpc_out_slice #(
    .WIDTH (WIDTH)
  ) u_out_slice (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (load),
    .i_load_data (load_data),
    .i_load_last (load_last),
    .i_out_ready (i_out_ready),
    .o_slot_free (slot_free),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .o_out_last  (o_out_last)
  );

endmodule

// File: tb/tb_ldpc_codeword_assembler.sv
// ---------------------------------------------------------------------------
// tb_ldpc_codeword_assembler
// Directed bench for ldpc_codeword_assembler with WIDTH=8, SYS_WORDS=4,
// PAR_WORDS=2, PUNC_WORDS=1. Expected codeword streams are built from the
// frame contents the bench itself loads.
// ---------------------------------------------------------------------------
module tb_ldpc_codeword_assembler;

`ifdef LDPC_ASM_PUNCTURE_EN
  localparam int PUNC = 1;
`else
  localparam int PUNC = 0;
`endif
  localparam int NSYS = 4;
  localparam int NPAR = 2;

  logic       i_clock;
  logic       i_reset;
  logic [7:0] i_sys_data;
  logic       i_sys_valid;
  logic       o_sys_ready;
  logic [7:0] i_par_data;
  logic       i_par_valid;
  logic       o_par_ready;
  logic [7:0] o_out_data;
  logic       o_out_valid;
  logic       o_out_last;
  logic       i_out_ready;

  ldpc_codeword_assembler #(
    .WIDTH      (8),
    .SYS_WORDS  (NSYS),
    .PAR_WORDS  (NPAR),
    .PUNC_WORDS (1)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_sys_data  (i_sys_data),
    .i_sys_valid (i_sys_valid),
    .o_sys_ready (o_sys_ready),
    .i_par_data  (i_par_data),
    .i_par_valid (i_par_valid),
    .o_par_ready (o_par_ready),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .o_out_last  (o_out_last),
    .i_out_ready (i_out_ready)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  logic [7:0] sys_mem [0:15];
  logic [7:0] par_mem [0:15];
  logic [8:0] exp_q [$];
  int sys_n, par_n, sys_idx, par_idx;
  int total, bad;
  int cyc, n_out, first_cyc, last_cyc;
  bit mon_en, excl_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    i_sys_valid = (sys_idx < sys_n);
    i_sys_data  = (sys_idx < sys_n) ? sys_mem[sys_idx] : 8'h00;
    i_par_valid = (par_idx < par_n);
    i_par_data  = (par_idx < par_n) ? par_mem[par_idx] : 8'h00;
  endtask

  // Frame f carries systematic 0x(f+1)0.. and parity 0xA0+16f..
  task automatic load_frames(input int nf);
    exp_q.delete();
    sys_n = NSYS * nf;
    par_n = NPAR * nf;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < NSYS; i++) begin
        sys_mem[f*NSYS+i] = 8'(16 * (f + 1) + i);
        if (i >= PUNC) exp_q.push_back({1'b0, sys_mem[f*NSYS+i]});
      end
      for (int j = 0; j < NPAR; j++) begin
        par_mem[f*NPAR+j] = 8'(8'hA0 + 16 * f + j);
        exp_q.push_back({(j == NPAR - 1), par_mem[f*NPAR+j]});
      end
    end
    sys_idx = 0;
    par_idx = 0;
    cyc = 0;
    n_out = 0;
    first_cyc = -1;
    last_cyc = -1;
    drive();
  endtask

  // One clock: observe at the falling edge, then advance the sources just
  // after the rising edge according to the handshakes seen.
  task automatic step();
    bit sys_fire, par_fire, have;
    logic [8:0] e;
    @(negedge i_clock);
    cyc++;
    if (mon_en && o_out_valid && i_out_ready) begin
      have = (exp_q.size() != 0);
      check("out_avail", {31'd0, have}, 32'd1);
      if (have) begin
        e = exp_q.pop_front();
        check("out_word", {23'd0, o_out_last, o_out_data}, {23'd0, e});
      end
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      n_out++;
    end
    if (excl_en) begin
      if (sys_idx < NSYS * (par_idx / NPAR + 1))
        check("par_ready_in_sys", {31'd0, o_par_ready}, 32'd0);
      else
        check("sys_ready_in_par", {31'd0, o_sys_ready}, 32'd0);
    end
    sys_fire = i_sys_valid && o_sys_ready;
    par_fire = i_par_valid && o_par_ready;
    @(posedge i_clock);
    #1;
    if (sys_fire) sys_idx++;
    if (par_fire) par_idx++;
    drive();
  endtask

  task automatic reset_dut();
    i_reset = 1'b1;
    i_out_ready = 1'b1;
    sys_n = 0;
    par_n = 0;
    sys_idx = 0;
    par_idx = 0;
    drive();
    exp_q.delete();
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    check("rst_valid", {31'd0, o_out_valid}, 32'd0);
    check("rst_data", {24'd0, o_out_data}, 32'd0);
    check("rst_last", {31'd0, o_out_last}, 32'd0);
    check("rst_sys_ready", {31'd0, o_sys_ready}, 32'd0);
    check("rst_par_ready", {31'd0, o_par_ready}, 32'd0);
  endtask

  task automatic run_to_end(input string tag);
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && sys_idx == sys_n && par_idx == par_n) break;
      step();
    end
    check({tag, "_drain"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    bit bp_done;
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    excl_en = 1'b0;
    i_reset = 1'b1;
    i_out_ready = 1'b1;
    sys_n = 0;
    par_n = 0;
    sys_idx = 0;
    par_idx = 0;
    drive();

    // Basic frame (also the puncture scenario when the macro is defined).
    reset_dut();
    mon_en = 1'b1;
    excl_en = 1'b1;
    load_frames(1);
    run_to_end("basic");
    check("basic_count", n_out, 6 - PUNC);
    check("basic_first_cyc", first_cyc, 3 + PUNC);
    check("basic_span", last_cyc - first_cyc, 6 - PUNC - 1);

    // Early parity: parity valid from the first cycle, readies exclusive.
    reset_dut();
    load_frames(1);
    run_to_end("early_par");
    check("early_par_count", n_out, 6 - PUNC);
    excl_en = 1'b0;

    // Backpressure on word 0x12 for three cycles.
    reset_dut();
    load_frames(1);
    bp_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && sys_idx == sys_n && par_idx == par_n) break;
      step();
      if (!bp_done && o_out_valid && o_out_data == 8'h12) begin
        bp_done = 1'b1;
        i_out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          step();
          check("bp_data", {24'd0, o_out_data}, 32'h12);
          check("bp_valid", {31'd0, o_out_valid}, 32'd1);
          check("bp_sys_ready", {31'd0, o_sys_ready}, 32'd0);
          check("bp_par_ready", {31'd0, o_par_ready}, 32'd0);
        end
        i_out_ready = 1'b1;
      end
    end
    check("bp_seen", {31'd0, bp_done}, 32'd1);
    check("bp_drain", exp_q.size(), 32'd0);
    check("bp_count", n_out, 6 - PUNC);

    // Back-to-back frames with everything held high.
    reset_dut();
    excl_en = 1'b1;
    load_frames(2);
    run_to_end("b2b");
    check("b2b_count", n_out, 12 - 2 * PUNC);
    check("b2b_span", last_cyc - first_cyc, 12 - PUNC - 1);
    excl_en = 1'b0;

    // Reset in the middle of a frame.
    reset_dut();
    mon_en = 1'b0;
    load_frames(1);
    for (int c = 0; c < 10 && sys_idx < 2; c++) step();
    check("mid_sys_taken", sys_idx, 32'd2);
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    check("mid_rst_valid", {31'd0, o_out_valid}, 32'd0);
    i_reset = 1'b0;
    load_frames(1);
    check("mid_init_sys_ready", {31'd0, o_sys_ready}, 32'd0);
    mon_en = 1'b1;
    run_to_end("mid_restart");
    check("mid_restart_count", n_out, 6 - PUNC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
